// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply and
// restoring divide, one result bit per clock, with a busy/done handshake.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] addend_q, addend_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             a_neg, b_neg, qbit;
  logic [WIDTH:0]   sum, shifted, trial;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rmd;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
    return ~v + {{(W2-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return sgn ? neg_w(v) : v;
  endfunction

  // Next-state, datapath step and result formatting.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    addend_d   = addend_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    a_neg   = is_signed & a[WIDTH-1];
    b_neg   = is_signed & b[WIDTH-1];
    sum     = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, addend_q};
    // Partial remainder is one bit wider than the divisor so the trial never wraps.
    shifted = {rem_q, acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, addend_q};
    qbit    = ~trial[WIDTH];
    prod    = neg_res_q ? neg_2w(acc_q) : acc_q;
    quo     = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rmd     = neg_rem_q ? neg_w(rem_q) : rem_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          op_d       = op;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          dz_d       = op & (b == {WIDTH{1'b0}});
          cnt_d      = {CW{1'b0}};
          rem_d      = {WIDTH{1'b0}};
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          if (op) begin
            addend_d = mag(b, b_neg);
            acc_d    = {{WIDTH{1'b0}}, mag(a, a_neg)};
          end else begin
            addend_d = mag(a, a_neg);
            acc_d    = {{WIDTH{1'b0}}, mag(b, b_neg)};
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (op_q) begin
          rem_d = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          acc_d = {acc_q[W2-1:WIDTH], acc_q[WIDTH-2:0], qbit};
        end else if (acc_q[0]) begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[W2-1:1]};
        end
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FINISH;
        end else begin
          state_d = RUN;
        end
      end
      FINISH: begin
        if (op_q) begin
          hi_d = rmd;
          lo_d = dz_q ? {WIDTH{1'b1}} : quo;
        end else begin
          hi_d = prod[W2-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        div_zero_d = op_q & dz_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      addend_q   <= {WIDTH{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      acc_q      <= {W2{1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      cnt_q      <= cnt_d;
      addend_q   <= addend_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, truncating signed division.
  task automatic model(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint      sx, sy, q, r;
    logic [63:0] t;
    dz = 1'b0;
    if (!o) begin
      if (s) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        t  = sx * sy;
      end else begin
        t = {32'h0, x} * {32'h0, y};
      end
      h = t[63:32];
      l = t[31:0];
    end else if (y == 32'h0) begin
      h  = x;
      l  = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      t  = q;
      l  = t[31:0];
      t  = r;
      h  = t[31:0];
    end else begin
      l = x / y;
      h = x % y;
    end
  endtask

  // Issue one operation and wait (bounded) for done; returns observations only.
  task automatic run_op(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt,
                        output logic [31:0] h, output logic [31:0] l, output logic dz);
    @(negedge clk);
    start = 1'b1; op = o; is_signed = s; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (lat < 60) begin
      @(posedge clk);
      #1 lat++;
      if (done) break;
      if (busy) bcnt++;
    end
    h  = hi;
    l  = lo;
    dz = div_zero;
  endtask

  task automatic test_reset();
    #23;
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h expected %h", hi, 32'h0); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h expected %h", lo, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b expected 0", div_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic        vo[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        vs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] va[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] vb[5]  = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] ehi[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h0};
    logic [31:0] elo[5] = '{32'h0000_0001, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000};
    int lat, bcnt;
    logic [31:0] h, l;
    logic dz;
    for (int i = 0; i < 5; i++) begin
      run_op(vo[i], vs[i], va[i], vb[i], lat, bcnt, h, l, dz);
      n_checks++; if (h !== ehi[i]) begin n_fail++; $display("FAIL dir%0d_hi got %h expected %h", i, h, ehi[i]); end
      n_checks++; if (l !== elo[i]) begin n_fail++; $display("FAIL dir%0d_lo got %h expected %h", i, l, elo[i]); end
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL dir%0d_latency got %0d expected 33", i, lat); end
      n_checks++; if (bcnt !== 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d expected 33", i, bcnt); end
      n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL dir%0d_dz got %b expected 0", i, dz); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done got %b expected 0", i, busy); end
      @(posedge clk);
      #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got %b expected 0", i, done); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt, n;
    logic [31:0] h, l;
    logic dz;
    run_op(1'b1, 1'b0, 32'h0000_1234, 32'h0, lat, bcnt, h, l, dz);
    n_checks++; if (h !== 32'h0000_1234) begin n_fail++; $display("FAIL dz_hi got %h expected %h", h, 32'h0000_1234); end
    n_checks++; if (l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_lo got %h expected %h", l, 32'hFFFF_FFFF); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b expected 1", dz); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL dz_latency got %0d expected 33", lat); end
    run_op(1'b1, 1'b1, 32'hFFFF_8000, 32'h0, lat, bcnt, h, l, dz);
    n_checks++; if (h !== 32'hFFFF_8000) begin n_fail++; $display("FAIL dz_signed_hi got %h expected %h", h, 32'hFFFF_8000); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_signed_flag got %b expected 1", dz); end
    // next accepted start clears the flag right away
    @(negedge clk);
    start = 1'b1; op = 1'b0; is_signed = 1'b0; a = 32'd3; b = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear got %b expected 0", div_zero); end
    n = 0;
    while (!done && n < 60) begin @(posedge clk); #1 n++; end
    n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL dz_after_lo got %h expected %h", lo, 32'd12); end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [31:0] x, y, h, l, eh, el;
    logic o, s, dz, edz;
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'($urandom_range(0, 15));
        1:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: y = $urandom;
      endcase
      model(o, s, x, y, eh, el, edz);
      run_op(o, s, x, y, lat, bcnt, h, l, dz);
      n_checks++; if (h !== eh || l !== el || dz !== edz || lat !== 33) begin
        n_fail++;
        $display("FAIL rand%0d op=%b sgn=%b a=%h b=%h got hi=%h lo=%h dz=%b lat=%0d expected hi=%h lo=%h dz=%b lat=33",
                 i, o, s, x, y, h, l, dz, lat, eh, el, edz);
      end
    end
  endtask

  task automatic test_ignored_start();
    int lat, busy_low;
    logic [31:0] eh, el;
    logic edz;
    model(1'b0, 1'b1, 32'h1234_5678, 32'hFEDC_BA98, eh, el, edz);
    @(negedge clk);
    start = 1'b1; op = 1'b0; is_signed = 1'b1; a = 32'h1234_5678; b = 32'hFEDC_BA98;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_low = 0;
    repeat (5) begin @(posedge clk); #1 lat++; end
    start = 1'b1; op = 1'b1; is_signed = 1'b0; a = 32'd99; b = 32'd0;
    @(posedge clk);
    #1 lat++; start = 1'b0;
    while (!done && lat < 60) begin
      if (!busy) busy_low++;
      @(posedge clk);
      #1 lat++;
    end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ign_latency got %0d expected 33", lat); end
    n_checks++; if (hi !== eh || lo !== el) begin n_fail++; $display("FAIL ign_result got %h_%h expected %h_%h", hi, lo, eh, el); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL ign_dz got %b expected 0", div_zero); end
    n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL ign_busy_gap got %0d expected 0", busy_low); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [31:0] h1, l1, eh, el;
    logic dz, edz;
    run_op(1'b1, 1'b0, 32'd1000, 32'd33, lat, bcnt, h1, l1, dz);
    n_checks++; if (l1 !== 32'd30 || h1 !== 32'd10) begin n_fail++; $display("FAIL b2b_first got %h_%h expected %h_%h", h1, l1, 32'd10, 32'd30); end
    model(1'b0, 1'b1, 32'hFFFF_0001, 32'h0001_0003, eh, el, edz);
    start = 1'b1; op = 1'b0; is_signed = 1'b1; a = 32'hFFFF_0001; b = 32'h0001_0003;
    @(posedge clk);
    #1 start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b expected 1", busy); end
    lat = 0;
    while (!done && lat < 60) begin
      n_checks++; if (hi !== h1 || lo !== l1) begin n_fail++; $display("FAIL b2b_hold got %h_%h expected %h_%h", hi, lo, h1, l1); end
      @(posedge clk);
      #1 lat++;
    end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency got %0d expected 33", lat); end
    n_checks++; if (hi !== eh || lo !== el) begin n_fail++; $display("FAIL b2b_second got %h_%h expected %h_%h", hi, lo, eh, el); end
    // results hold while idle
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (hi !== eh || lo !== el || done !== 1'b0) begin n_fail++; $display("FAIL idle_hold got %h_%h done=%b expected %h_%h done=0", hi, lo, done, eh, el); end
  endtask

  task automatic test_reset_mid();
    int seen, lat, bcnt;
    logic [31:0] x, y, h, l, eh, el;
    logic dz, edz;
    @(negedge clk);
    start = 1'b1; op = 1'b0; is_signed = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_hilo got %h_%h expected 0_0", hi, lo); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got busy=%b done=%b expected 0 0", busy, done); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1 if (done || busy) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d expected 0", seen); end
    x = $urandom; y = 32'($urandom_range(1, 1000));
    model(1'b1, 1'b1, x, y, eh, el, edz);
    run_op(1'b1, 1'b1, x, y, lat, bcnt, h, l, dz);
    n_checks++; if (h !== eh || l !== el || lat !== 33) begin n_fail++; $display("FAIL rstmid_fresh got %h_%h lat=%0d expected %h_%h lat=33", h, l, lat, eh, el); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
